// File: rtl/mem_access_pkg.sv
// mem_access_pkg
//   Shared definitions for the load/store unit: funct3 codes, FSM state
//   encoding, byte-enable width and small request-decode helpers used when
//   a request is accepted.
package mem_access_pkg;

  localparam int BE_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_TRAP   = 2'd3   // only reachable when misaligned accesses trap
  } state_e;

  // Byte enables for a request; any unknown funct3 behaves as a word.
  function automatic logic [BE_W-1:0] calc_be(input logic [2:0] funct3,
                                               input logic [1:0] off);
    logic [BE_W-1:0] be;
    case (funct3)
      F3_B, F3_BU: be = 4'b0001 << off;
      F3_H, F3_HU: be = 4'b0011 << {off[1], 1'b0};
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across lanes so memory can pick any enabled lane.
  function automatic logic [31:0] replicate_wdata(input logic [2:0]  funct3,
                                                  input logic [31:0] wdata);
    logic [31:0] rep;
    case (funct3)
      F3_B, F3_BU: rep = {4{wdata[7:0]}};
      F3_H, F3_HU: rep = {2{wdata[15:0]}};
      default:     rep = wdata;
    endcase
    return rep;
  endfunction

  // True when the access does not fit its natural alignment.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] off);
    logic mis;
    case (funct3)
      F3_B, F3_BU: mis = 1'b0;
      F3_H, F3_HU: mis = off[0];
      default:     mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_data_extender.sv
// load_data_extender
//   Combinational lane select and sign/zero extension of a read word.
//   Ports:
//     rdata_i   - 32-bit word returned by data memory
//     funct3_i  - load funct3 (B/H/W/BU/HU; others treated as W)
//     addr_lo_i - byte offset within the word
//     data_o    - 32-bit extended load result
module load_data_extender
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and half-word lanes.
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo_i)
      2'b00:   byte_s = rdata_i[7:0];
      2'b01:   byte_s = rdata_i[15:8];
      2'b10:   byte_s = rdata_i[23:16];
      2'b11:   byte_s = rdata_i[31:24];
      default: byte_s = rdata_i[7:0];
    endcase
    // addr[0] is ignored for half-words.
    if (addr_lo_i[1]) begin
      half_s = rdata_i[31:16];
    end else begin
      half_s = rdata_i[15:0];
    end
  end

  // Extend the selected lane according to the load type.
  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_B:    data_o = {{24{byte_s[7]}}, byte_s};
      F3_BU:   data_o = {24'h000000, byte_s};
      F3_H:    data_o = {{16{half_s[15]}}, half_s};
      F3_HU:   data_o = {16'h0000, half_s};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store stage between execute and data memory. Accepts one request
//   at a time in IDLE, drives a word-aligned memory port with byte enables
//   until acknowledged, and returns extended load data with a one-cycle
//   wb_valid strobe.
//   Ports:
//     req_*   - request from execute (valid/ready handshake, accepted in IDLE)
//     dmem_*  - word-aligned data-memory port, request held until dmem_ack
//     wb_*    - writeback result; wb_rd/wb_data hold until the next load
//     busy    - a request is in flight
//     misalign (only with MISALIGN_TRAP_EN) - one-cycle trap pulse
//   Build option: define MISALIGN_TRAP_EN to trap misaligned half-word and
//   word accesses instead of silently aligning them.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [BE_W-1:0]   dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic [RD_W-1:0]   wb_rd,
  output logic [31:0]       wb_data,
  output logic              busy
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  state_e              state_q, state_d;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [BE_W-1:0]     be_q;
  logic [31:0]         wdata_q;
  logic [RD_W-1:0]     rd_q;
  logic [RD_W-1:0]     wb_rd_q;
  logic [31:0]         wb_data_q;
  logic                accept_s;
  logic                mis_s;
  logic                load_done_s;
  logic [31:0]         load_data_s;

  assign accept_s    = req_valid && (state_q == ST_IDLE);
  assign load_done_s = (state_q == ST_ACCESS) && dmem_ack && !we_q;

`ifdef MISALIGN_TRAP_EN
  assign mis_s = is_misaligned(req_funct3, req_addr[1:0]);
`else
  assign mis_s = 1'b0;
`endif

  load_data_extender u_ext (
    .rdata_i   (dmem_rdata),
    .funct3_i  (f3_q),
    .addr_lo_i (addr_q[1:0]),
    .data_o    (load_data_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = mis_s ? ST_TRAP : ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (dmem_ack) begin
          state_d = we_q ? ST_IDLE : ST_RESP;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_TRAP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the state register only.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    dmem_be   = 4'b0000;
    wb_valid  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misalign  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_ACCESS: begin
        dmem_req = 1'b1;
        dmem_we  = we_q;
        dmem_be  = be_q;
      end
      ST_RESP: wb_valid = 1'b1;
      ST_TRAP: begin
`ifdef MISALIGN_TRAP_EN
        misalign = 1'b1;
`else
        busy = 1'b1;
`endif
      end
      default: begin
        req_ready = 1'b0;
        busy      = 1'b1;
      end
    endcase
  end

  // Request capture; fields are frozen for the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0000_0000;
      rd_q    <= '0;
    end else if (accept_s) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      be_q    <= calc_be(req_funct3, req_addr[1:0]);
      wdata_q <= replicate_wdata(req_funct3, req_wdata);
      rd_q    <= req_rd;
    end
  end

  // Load result capture on ack; held until the next load completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_rd_q   <= '0;
      wb_data_q <= 32'h0000_0000;
    end else if (load_done_s) begin
      wb_rd_q   <= rd_q;
      wb_data_q <= load_data_s;
    end
  end

  // Memory port always presents the word address of the held request.
  assign dmem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign dmem_wdata = wdata_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, busy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int tests = 0;
  int fails = 0;

  // observations captured by run_txn
  logic        o_timeout, o_req0, o_we, o_stable, o_wb1, o_ready1, o_wb2, o_ready2;
  logic [31:0] o_addr, o_wdata, o_wb1_data;
  logic [3:0]  o_be;
  logic [4:0]  o_wb1_rd;
  logic [31:0] last_wb;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy)
`ifdef MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model (arithmetic on the rules) ----------
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    int unsigned off, v;
    off = addr % 4;
    case (f3)
      3'd0, 3'd4: begin
        v = (rdata >> (8 * off)) % 256;
        if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (rdata >> (16 * (off / 2))) % 65536;
        if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned off, v;
    off = addr % 4;
    case (f3)
      3'd0, 3'd4: v = 1 << off;
      3'd1, 3'd5: v = 3 << (2 * (off / 2));
      default:    v = 15;
    endcase
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int unsigned v;
    case (f3)
      3'd0:    v = (wd % 256) * 32'h0101_0101;
      3'd1:    v = (wd % 65536) * 32'h0001_0001;
      default: v = wd;
    endcase
    return v;
  endfunction

  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] addr);
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    if (f3 == 3'd1 || f3 == 3'd5) return (addr % 2) != 0;
    return (addr % 4) != 0;
  endfunction

  // ---------------- one request through a bench-side memory ------------
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] rdata, input int delay, input logic hold);
    int t;
    @(negedge clk);
    t = 0;
    while (req_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    o_timeout = (req_ready !== 1'b1);
    tests++;
    if (o_timeout) begin
      fails++;
      $display("FAIL txn_ready_timeout: req_ready=%b after %0d cycles, required 1", req_ready, t);
      return;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
    req_wdata = wd; req_rd = rd;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    o_req0 = dmem_req; o_addr = dmem_addr; o_be = dmem_be; o_wdata = dmem_wdata;
    o_we = dmem_we; o_stable = (req_ready === 1'b0);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (dmem_req !== 1'b1 || dmem_addr !== o_addr || dmem_be !== o_be ||
          dmem_wdata !== o_wdata || dmem_we !== o_we || req_ready !== 1'b0)
        o_stable = 1'b0;
    end
    dmem_ack = 1'b1; dmem_rdata = rdata;
    @(negedge clk);
    dmem_ack = 1'b0; dmem_rdata = $urandom; req_valid = 1'b0;
    o_wb1 = wb_valid; o_wb1_data = wb_data; o_wb1_rd = wb_rd; o_ready1 = req_ready;
    @(negedge clk);
    o_wb2 = wb_valid; o_ready2 = req_ready;
  endtask

  // ---------------- tests ----------------------------------------------
  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #12;
    tests++;
    if ({dmem_req, dmem_we, dmem_be, wb_valid, busy, req_ready} !== 9'b0_0_0000_0_0_1) begin
      fails++;
      $display("FAIL reset_ctrl: got %b required %b",
               {dmem_req, dmem_we, dmem_be, wb_valid, busy, req_ready}, 9'b0_0_0000_0_0_1);
    end
    tests++;
    if ({dmem_addr, dmem_wdata, wb_rd, wb_data} !== 101'd0) begin
      fails++;
      $display("FAIL reset_data: addr=%h wdata=%h rd=%h data=%h required all zero",
               dmem_addr, dmem_wdata, wb_rd, wb_data);
    end
`ifdef MISALIGN_TRAP_EN
    tests++;
    if (misalign !== 1'b0) begin
      fails++;
      $display("FAIL reset_misalign: got %b required 0", misalign);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_byte;
    run_txn(1'b0, 3'd0, 32'h103, $urandom, 5'd7, 32'h8012_3456, 0, 1'b0);
    tests++;
    if ({o_req0, o_addr, o_be} !== {1'b1, 32'h100, 4'b1000}) begin
      fails++;
      $display("FAIL lb_port: req=%b addr=%h be=%b required 1 00000100 1000", o_req0, o_addr, o_be);
    end
    tests++;
    if ({o_wb1, o_wb1_data, o_wb1_rd, o_wb2} !== {1'b1, 32'hFFFF_FF80, 5'd7, 1'b0}) begin
      fails++;
      $display("FAIL lb_wb: valid=%b data=%h rd=%0d next_valid=%b required 1 ffffff80 7 0",
               o_wb1, o_wb1_data, o_wb1_rd, o_wb2);
    end
    run_txn(1'b0, 3'd4, 32'h103, $urandom, 5'd8, 32'h8012_3456, 0, 1'b0);
    tests++;
    if ({o_wb1, o_wb1_data} !== {1'b1, 32'h0000_0080}) begin
      fails++;
      $display("FAIL lbu_wb: valid=%b data=%h required 1 00000080", o_wb1, o_wb1_data);
    end
  endtask

  task automatic test_store_half;
    run_txn(1'b1, 3'd1, 32'h22, 32'h0000_BEEF, 5'd3, $urandom, 0, 1'b0);
    tests++;
    if ({o_we, o_be, o_wdata, o_addr} !== {1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h20}) begin
      fails++;
      $display("FAIL sh_port: we=%b be=%b wdata=%h addr=%h required 1 1100 beefbeef 00000020",
               o_we, o_be, o_wdata, o_addr);
    end
    tests++;
    if ({o_wb1, o_ready1, o_wb1_data} !== {1'b0, 1'b1, 32'h0000_0080}) begin
      fails++;
      $display("FAIL sh_after: wb_valid=%b ready=%b held_data=%h required 0 1 00000080",
               o_wb1, o_ready1, o_wb1_data);
    end
  endtask

  task automatic test_ack_wait;
    logic [31:0] rd_word;
    rd_word = $urandom;
    run_txn(1'b0, 3'd2, 32'h40, $urandom, 5'd12, rd_word, 3, 1'b1);
    tests++;
    if ({o_stable, o_addr, o_be} !== {1'b1, 32'h40, 4'b1111}) begin
      fails++;
      $display("FAIL ackwait_port: stable=%b addr=%h be=%b required 1 00000040 1111",
               o_stable, o_addr, o_be);
    end
    tests++;
    if ({o_wb1, o_wb1_data, o_wb2, o_ready2} !== {1'b1, rd_word, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL ackwait_wb: valid=%b data=%h next=%b ready=%b required 1 %h 0 1",
               o_wb1, o_wb1_data, o_wb2, o_ready2, rd_word);
    end
  endtask

  task automatic test_misalign;
`ifdef MISALIGN_TRAP_EN
    int mis_cnt, req_cnt, wb_cnt;
    mis_cnt = 0; req_cnt = 0; wb_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd1; req_addr = 32'h05; req_rd = 5'd4;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) req_valid = 1'b0;
      if (misalign === 1'b1) mis_cnt++;
      if (dmem_req === 1'b1) req_cnt++;
      if (wb_valid === 1'b1) wb_cnt++;
    end
    tests++;
    if (mis_cnt != 1 || req_cnt != 0 || wb_cnt != 0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL misalign_trap: pulses=%0d dmem_req=%0d wb=%0d ready=%b required 1 0 0 1",
               mis_cnt, req_cnt, wb_cnt, req_ready);
    end
`else
    run_txn(1'b0, 3'd1, 32'h05, $urandom, 5'd4, 32'h1234_8765, 1, 1'b0);
    tests++;
    if ({o_addr, o_be, o_wb1, o_wb1_data} !== {32'h04, 4'b0011, 1'b1, 32'hFFFF_8765}) begin
      fails++;
      $display("FAIL misalign_silent: addr=%h be=%b valid=%b data=%h required 00000004 0011 1 ffff8765",
               o_addr, o_be, o_wb1, o_wb1_data);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int wb_cnt;
    logic [31:0] rd_word;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h80; req_rd = 5'd9;
    @(negedge clk);
    req_valid = 1'b0;
    tests++;
    if (dmem_req !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_access: dmem_req=%b required 1", dmem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({dmem_req, busy} !== 2'b00) begin
      fails++;
      $display("FAIL rstmid_async: dmem_req=%b busy=%b required 0 0", dmem_req, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wb_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (wb_valid === 1'b1) wb_cnt++;
    end
    tests++;
    if (wb_cnt != 0) begin
      fails++;
      $display("FAIL rstmid_nowb: wb pulses=%0d required 0", wb_cnt);
    end
    rd_word = $urandom;
    run_txn(1'b0, 3'd2, 32'h84, $urandom, 5'd11, rd_word, 0, 1'b0);
    tests++;
    if ({o_wb1, o_wb1_data, o_wb1_rd} !== {1'b1, rd_word, 5'd11}) begin
      fails++;
      $display("FAIL rstmid_next: valid=%b data=%h rd=%0d required 1 %h 11",
               o_wb1, o_wb1_data, o_wb1_rd, rd_word);
    end
  endtask

  task automatic test_back_to_back;
    logic        b_we[3];
    logic [2:0]  b_f3[3];
    logic [31:0] b_addr[3], b_wd[3], b_rdata[3];
    logic [31:0] exp_q[$];
    logic [31:0] last_seen, a_s;
    int idx, cur, acc_cnt, mem_cnt, wb_cnt;
    logic prev_req, pend;
    b_we    = '{1'b0, 1'b1, 1'b0};
    b_f3    = '{3'd2, 3'd2, 3'd5};
    b_addr  = '{32'h200, 32'h204, 32'h206};
    b_wd    = '{$urandom, $urandom, $urandom};
    b_rdata = '{$urandom, $urandom, 32'hFFFF_0000};
    idx = 0; cur = 0; acc_cnt = 0; mem_cnt = 0; wb_cnt = 0; prev_req = 1'b0;
    last_seen = 32'h0;
    @(negedge clk);
    req_valid = 1'b1; req_we = b_we[0]; req_funct3 = b_f3[0]; req_addr = b_addr[0];
    req_wdata = b_wd[0]; req_rd = 5'd10;
    for (int c = 0; c < 30; c++) begin
      pend = 1'b0;
      if (dmem_req === 1'b1 && prev_req !== 1'b1) begin
        mem_cnt++;
        a_s = b_addr[cur];
        tests++;
        if ({dmem_we, dmem_be, dmem_addr} !== {b_we[cur], m_be(b_f3[cur], a_s), a_s[31:2], 2'b00}) begin
          fails++;
          $display("FAIL b2b_port%0d: we=%b be=%b addr=%h", cur, dmem_we, dmem_be, dmem_addr);
        end
      end
      prev_req = dmem_req;
      dmem_ack = dmem_req; dmem_rdata = b_rdata[cur];
      if (wb_valid === 1'b1) begin
        wb_cnt++;
        last_seen = wb_data;
        tests++;
        if (exp_q.size() == 0 || wb_data !== exp_q[0]) begin
          fails++;
          $display("FAIL b2b_wb: data=%h required %h", wb_data,
                   (exp_q.size() == 0) ? 32'hx : exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (req_valid === 1'b1 && req_ready === 1'b1) begin
        tests++;
        if (busy !== 1'b0) begin
          fails++;
          $display("FAIL b2b_accept_idle: busy=%b at accept required 0", busy);
        end
        if (idx < 3) begin
          if (!b_we[idx]) exp_q.push_back(m_load(b_f3[idx], b_addr[idx], b_rdata[idx]));
          cur = idx;
        end
        idx++; acc_cnt++; pend = 1'b1;
      end
      @(posedge clk);
      #1;
      if (pend) begin
        if (idx < 3) begin
          req_we = b_we[idx]; req_funct3 = b_f3[idx]; req_addr = b_addr[idx];
          req_wdata = b_wd[idx]; req_rd = 5'(10 + idx);
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    tests++;
    if (acc_cnt != 3 || mem_cnt != 3 || wb_cnt != 2) begin
      fails++;
      $display("FAIL b2b_counts: accepts=%0d accesses=%0d wb=%0d required 3 3 2",
               acc_cnt, mem_cnt, wb_cnt);
    end
    tests++;
    if (last_seen !== 32'h0000_FFFF) begin
      fails++;
      $display("FAIL b2b_lhu: data=%h required 0000ffff", last_seen);
    end
  endtask

  task automatic test_random;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rdata;
    logic [4:0]  rd;
    int          delay;
    for (int i = 0; i < 24; i++) begin
      we    = (i == 0) ? 1'b0 : 1'($urandom % 2);
      f3    = we ? 3'($urandom % 3) : 3'($urandom % 8);
      addr  = $urandom;
`ifdef MISALIGN_TRAP_EN
      if (m_mis(f3, addr)) addr = addr & 32'hFFFF_FFFC;
`endif
      wd    = $urandom;
      rdata = $urandom;
      rd    = 5'($urandom % 32);
      delay = $urandom % 4;
      run_txn(we, f3, addr, wd, rd, rdata, delay, 1'($urandom % 2));
      tests++;
      if ({o_we, o_be, o_addr, o_stable} !== {we, m_be(f3, addr), addr[31:2], 2'b00, 1'b1}) begin
        fails++;
        $display("FAIL rnd%0d_port: we=%b be=%b addr=%h stable=%b required %b %b %h 1",
                 i, o_we, o_be, o_addr, o_stable, we, m_be(f3, addr), {addr[31:2], 2'b00});
      end
      if (we) begin
        tests++;
        if ({o_wdata, o_wb1, o_ready1, o_wb1_data} !== {m_wdata(f3, wd), 1'b0, 1'b1, last_wb}) begin
          fails++;
          $display("FAIL rnd%0d_store: wdata=%h wb=%b ready=%b held=%h required %h 0 1 %h",
                   i, o_wdata, o_wb1, o_ready1, o_wb1_data, m_wdata(f3, wd), last_wb);
        end
      end else begin
        tests++;
        if ({o_wb1, o_wb1_data, o_wb1_rd, o_wb2} !== {1'b1, m_load(f3, addr, rdata), rd, 1'b0}) begin
          fails++;
          $display("FAIL rnd%0d_load: f3=%0d valid=%b data=%h rd=%0d next=%b required 1 %h %0d 0",
                   i, f3, o_wb1, o_wb1_data, o_wb1_rd, o_wb2, m_load(f3, addr, rdata), rd);
        end
        last_wb = m_load(f3, addr, rdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_ack_wait();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store stage between execute and data memory in the RISC-V core.
- Accepts one memory request at a time and drives a word-aligned data-memory port with byte enables.
- For loads, selects the addressed byte or half-word lane and sign- or zero-extends it to 32 bits.
- Delivers the result to writeback with a valid strobe.

Parameters:
- ADDR_W, 32, address width of the request and data-memory ports.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  core clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  execute stage presents a memory request.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_rd  in  RD_W  load destination register.
- dmem_req  out  1  memory access request; held until ack.
- dmem_we  out  1  write strobe.
- dmem_addr  out  ADDR_W  word address; bits [1:0] always 0.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  memory completed the access; rdata valid this cycle for reads.
- dmem_rdata  in  32  read word.
- wb_valid  out  1  one-cycle strobe: wb_data/wb_rd valid.
- wb_rd  out  RD_W  destination register.
- wb_data  out  32  extended load result.
- busy  out  1  request in flight (state != IDLE).

Behaviour:
- Reset: state IDLE. dmem_req, dmem_we, dmem_be, wb_valid and busy are 0. dmem_addr, dmem_wdata, wb_rd and wb_data are 0.
- Reset asserted mid-access abandons the outstanding request immediately. No writeback is produced.
- States and transitions:
  - IDLE -> ACCESS on req_valid & req_ready. All request fields are registered; the request is not re-sampled afterwards.
  - ACCESS: dmem_req = 1 with stable addr, be, we and wdata until dmem_ack, which may arrive in the first ACCESS cycle.
  - On ack with a store: -> IDLE. No wb_valid.
  - On ack with a load: capture dmem_rdata, then -> RESP.
  - RESP: wb_valid = 1 for exactly one cycle, then -> IDLE.
- Latency: accept at cycle N, dmem_req at N+1. With ack at N+1, wb_valid at N+2. Each ack-wait cycle adds one cycle.
- Throughput: at most one request every 2 cycles (store) or 3 cycles (load). req_ready is low in ACCESS and RESP.
- Byte enables:
  - B/BU: be = 0001 << addr[1:0].
  - H/HU: be = 0011 << {addr[1],0}.
  - W: be = 1111.
- Store data: byte is replicated to all 4 lanes; half-word is replicated to both halves; word is passed through.
- Load extraction:
  - Lane is selected by the registered addr[1:0] (or addr[1] for half-words).
  - B/H are sign-extended from bit 7/15; BU/HU are zero-extended.
  - Example: lane 0x80 gives LB = 0xFFFFFF80 and LBU = 0x00000080.
- Unsupported funct3 (011, 110, 111): treated as word access.
- Misalignment (macro absent): low address bits are ignored. Half-words ignore addr[0]; words ignore addr[1:0].
- wb_rd and wb_data hold their values after wb_valid drops, until the next load response.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Enabled: adds output misalign (1 bit).
  - A half-word with addr[0] = 1, or a word with addr[1:0] != 0, is accepted but never sent to memory.
  - The unit pulses misalign for one cycle in place of the ACCESS cycle and returns to IDLE.
  - No wb_valid.
  - misalign resets to 0.
- Disabled: no misalign port; silent alignment as described in Behaviour.

Decomposition:
- Shared package mem_access_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State encoding IDLE/ACCESS/RESP.
  - Byte-enable width constant.
- One combinational sub-module, load_data_extender: inputs rdata, funct3 and addr[1:0]; outputs the 32-bit extended result.

Test Plan:
- Load byte: LB addr 0x103, rdata 0x80123456, ack in the first ACCESS cycle.
  - Expect dmem_addr 0x100, be 1000.
  - Expect wb_data 0xFFFFFF80 two cycles after accept.
  - LBU of the same address gives 0x00000080.
- Store half-word: SH addr 0x22, wdata 0x0000BEEF.
  - Expect be 1100, dmem_wdata 0xBEEFBEEF, dmem_we 1.
  - Expect no wb_valid and req_ready high the cycle after ack.
- Ack wait: LW addr 0x40 with ack delayed 3 cycles.
  - dmem_req and dmem_addr stay stable for 3 cycles; wb_valid is a single pulse.
  - req_valid held high during the access is not re-accepted.
- Reset mid-access: assert rst_n low during ACCESS.
  - dmem_req drops asynchronously; no wb_valid after release; next request proceeds normally.
- Misalignment: LH addr 0x05.
  - Without the macro: be 0011, data taken from lane 0.
  - With MISALIGN_TRAP_EN: misalign pulses, dmem_req never rises, no wb_valid.
- Back-to-back: LW, SW, LHU issued with req_valid held high.
  - Each request is accepted only in IDLE.
  - Results appear in order; LHU of 0xFFFF gives 0x0000FFFF.
